// File: rtl/cpu.sv
// cpu: small multi-cycle 32-bit load/store core.
//
// Sixteen 32-bit registers and a byte-addressed little-endian memory space.
// Instruction fetches and data loads share the read port. Stores use the
// write port. Both ports use ready handshakes.
//
// Optional feature: define CPU_MUL_EN to enable opcode 0x12 (MUL). In the
// default build that opcode executes as a NOP.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   m_in_addr        read byte address (fetch pc or load effective address)
//   m_in_data        read data, byte at addr in [7:0]
//   m_in_ready       m_in_data is valid for m_in_addr this cycle
//   m_out_addr       write byte address
//   m_out_data       write data, low bytes used for narrow writes
//   m_out_sig_write  0 none, 1 byte, 2 halfword, 3 word
//   m_out_ready      write accepted at this clock edge
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | m_in_addr=pc, latch instruction when m_in_ready
// S_EXEC  | decode/execute, compute ea for memory ops
// S_LOAD  | m_in_addr=ea, write rd when m_in_ready
// S_STORE | write port driven, hold until m_out_ready
// S_HALT  | idle until reset
module cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] m_in_addr,
    input  logic [31:0] m_in_data,
    input  logic        m_in_ready,
    output logic [31:0] m_out_addr,
    output logic [31:0] m_out_data,
    output logic [1:0]  m_out_sig_write,
    input  logic        m_out_ready
);

    localparam logic [7:0] OP_LI   = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h02;
    localparam logic [7:0] OP_SUB  = 8'h03;
    localparam logic [7:0] OP_AND  = 8'h04;
    localparam logic [7:0] OP_OR   = 8'h05;
    localparam logic [7:0] OP_XOR  = 8'h06;
    localparam logic [7:0] OP_ADDI = 8'h07;
    localparam logic [7:0] OP_SHL  = 8'h08;
    localparam logic [7:0] OP_SHR  = 8'h09;
    localparam logic [7:0] OP_LW   = 8'h0A;
    localparam logic [7:0] OP_LB   = 8'h0B;
    localparam logic [7:0] OP_SW   = 8'h0C;
    localparam logic [7:0] OP_SH   = 8'h0D;
    localparam logic [7:0] OP_SB   = 8'h0E;
    localparam logic [7:0] OP_BEQ  = 8'h0F;
    localparam logic [7:0] OP_BNE  = 8'h10;
    localparam logic [7:0] OP_JMP  = 8'h11;
`ifdef CPU_MUL_EN
    localparam logic [7:0] OP_MUL  = 8'h12;
`endif
    localparam logic [7:0] OP_HALT = 8'h1F;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_LOAD,
        S_STORE,
        S_HALT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] regs [16];
    logic [31:0] pc, pc_nxt;
    logic [31:0] command;
    logic [31:0] ea;

    logic [7:0]  op;
    logic [3:0]  rd_a, rs1_a, rs2_a;
    logic [31:0] imm_s, rd_v, rs1_v, rs2_v, ea_calc, br_tgt;

    logic        reg_we;
    logic [31:0] reg_wd;
    logic        st_start;
    logic [1:0]  st_size;

    assign op      = command[31:24];
    assign rd_a    = command[23:20];
    assign rs1_a   = command[19:16];
    assign rs2_a   = command[15:12];
    assign imm_s   = {{16{command[15]}}, command[15:0]};
    assign rd_v    = regs[rd_a];
    assign rs1_v   = regs[rs1_a];
    assign rs2_v   = regs[rs2_a];
    assign ea_calc = rs1_v + imm_s;
    // pc already points past the branch when it executes
    assign br_tgt  = pc - 32'd4 + imm_s;

    assign m_in_addr = (state == S_LOAD) ? ea : pc;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        reg_we    = 1'b0;
        reg_wd    = '0;
        st_start  = 1'b0;
        st_size   = 2'd0;
        case (state)
            S_FETCH: begin
                if (m_in_ready) begin
                    state_nxt = S_EXEC;
                    pc_nxt    = pc + 32'd4;
                end
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                case (op)
                    OP_LI:   begin reg_we = 1'b1; reg_wd = imm_s;                  end
                    OP_ADD:  begin reg_we = 1'b1; reg_wd = rs1_v + rs2_v;          end
                    OP_SUB:  begin reg_we = 1'b1; reg_wd = rs1_v - rs2_v;          end
                    OP_AND:  begin reg_we = 1'b1; reg_wd = rs1_v & rs2_v;          end
                    OP_OR:   begin reg_we = 1'b1; reg_wd = rs1_v | rs2_v;          end
                    OP_XOR:  begin reg_we = 1'b1; reg_wd = rs1_v ^ rs2_v;          end
                    OP_ADDI: begin reg_we = 1'b1; reg_wd = ea_calc;                end
                    OP_SHL:  begin reg_we = 1'b1; reg_wd = rs1_v << rs2_v[4:0];    end
                    OP_SHR:  begin reg_we = 1'b1; reg_wd = rs1_v >> rs2_v[4:0];    end
`ifdef CPU_MUL_EN
                    OP_MUL:  begin reg_we = 1'b1; reg_wd = rs1_v * rs2_v;          end
`endif
                    OP_LW, OP_LB: state_nxt = S_LOAD;
                    OP_SW:   begin st_start = 1'b1; st_size = 2'd3; state_nxt = S_STORE; end
                    OP_SH:   begin st_start = 1'b1; st_size = 2'd2; state_nxt = S_STORE; end
                    OP_SB:   begin st_start = 1'b1; st_size = 2'd1; state_nxt = S_STORE; end
                    OP_BEQ:  if (rd_v == rs1_v) pc_nxt = br_tgt;
                    OP_BNE:  if (rd_v != rs1_v) pc_nxt = br_tgt;
                    OP_JMP:  pc_nxt = br_tgt;
                    OP_HALT: state_nxt = S_HALT;
                    default: ;
                endcase
            end
            S_LOAD: begin
                if (m_in_ready) begin
                    reg_we    = 1'b1;
                    reg_wd    = (op == OP_LB) ? {24'h0, m_in_data[7:0]} : m_in_data;
                    state_nxt = S_FETCH;
                end
            end
            S_STORE: begin
                if (m_out_ready) state_nxt = S_FETCH;
            end
            S_HALT: ;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_FETCH;
            pc              <= RESET_PC;
            command         <= '0;
            ea              <= '0;
            m_out_addr      <= '0;
            m_out_data      <= '0;
            m_out_sig_write <= 2'd0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == S_FETCH && m_in_ready) command <= m_in_data;
            // ea is captured before any writeback, so rd==rs1 loads are safe
            if (state == S_EXEC) ea <= ea_calc;
            if (reg_we) regs[rd_a] <= reg_wd;
            if (st_start) begin
                m_out_addr      <= ea_calc;
                m_out_data      <= rd_v;
                m_out_sig_write <= st_size;
            end else if (state == S_STORE && m_out_ready) begin
                m_out_sig_write <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] m_in_addr, m_in_data, m_out_addr, m_out_data;
    logic        m_in_ready = 1'b1;
    logic        m_out_ready = 1'b1;
    logic [1:0]  m_out_sig_write;

    cpu #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .m_in_addr(m_in_addr), .m_in_data(m_in_data), .m_in_ready(m_in_ready),
        .m_out_addr(m_out_addr), .m_out_data(m_out_data),
        .m_out_sig_write(m_out_sig_write), .m_out_ready(m_out_ready)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    logic [9:0] a0;
    assign a0 = m_in_addr[9:0];
    assign m_in_data = {mem[a0 + 10'd3], mem[a0 + 10'd2], mem[a0 + 10'd1], mem[a0]};

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  nchecks = 0, npass = 0, writes = 0, sig_cycles = 0, wp = 0;

    // write-port monitor: each accepted store is checked against the scoreboard
    always @(negedge clk) begin
        if (!reset && m_out_sig_write != 2'd0) begin
            sig_cycles++;
            if (m_out_ready) begin
                writes++;
                nchecks++;
                if (sb.size() == 0) begin
                    $display("FAIL store_unexpected: got addr=%h data=%h sig=%0d, required no store",
                             m_out_addr, m_out_data, m_out_sig_write);
                end else begin
                    mon_e = sb.pop_front();
                    if (m_out_addr !== mon_e.addr || m_out_data !== mon_e.data ||
                        m_out_sig_write !== mon_e.size)
                        $display("FAIL store_sb: got addr=%h data=%h sig=%0d, required addr=%h data=%h sig=%0d",
                                 m_out_addr, m_out_data, m_out_sig_write, mon_e.addr, mon_e.data, mon_e.size);
                    else
                        npass++;
                end
                mem[m_out_addr[9:0]] = m_out_data[7:0];
                if (m_out_sig_write >= 2'd2) mem[m_out_addr[9:0] + 10'd1] = m_out_data[15:8];
                if (m_out_sig_write == 2'd3) begin
                    mem[m_out_addr[9:0] + 10'd2] = m_out_data[23:16];
                    mem[m_out_addr[9:0] + 10'd3] = m_out_data[31:24];
                end
            end
        end
    end

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic begin_prog();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        sb.delete();
        wp = 0;
    endtask

    task automatic put(input logic [31:0] w);
        mem[wp] = w[7:0]; mem[wp+1] = w[15:8]; mem[wp+2] = w[23:16]; mem[wp+3] = w[31:24];
        wp += 4;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        wr_t e;
        e.addr = addr; e.data = data; e.size = size;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bit found;
        int w0;
        m_in_ready = 1'b1; m_out_ready = 1'b0;
        begin_prog();
        put(enc(8'h01, 4'd0, 4'd0, 16'h0055));
        put(enc(8'h01, 4'd3, 4'd0, 16'h0040));
        put(enc(8'h0C, 4'd0, 4'd3, 16'h0000));
        put(enc(8'h1F, 4'd0, 4'd0, 16'h0000));
        release_reset();
        w0 = writes;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m_out_sig_write != 2'd0) begin found = 1'b1; break; end
        end
        nchecks++;
        if (!found) $display("FAIL reset_store_pending: sig stayed 0, required nonzero within 30 cycles");
        else npass++;
        #2 reset = 1'b1;
        #1;
        nchecks++;
        if (m_in_addr !== 32'h0) $display("FAIL reset_pc: m_in_addr=%h required 00000000", m_in_addr);
        else npass++;
        nchecks++;
        if (m_out_sig_write !== 2'd0) $display("FAIL reset_sig: sig=%0d required 0", m_out_sig_write);
        else npass++;
        nchecks++;
        if (m_out_addr !== 32'h0 || m_out_data !== 32'h0)
            $display("FAIL reset_wport: addr=%h data=%h required 0/0", m_out_addr, m_out_data);
        else npass++;
        nchecks++;
        if (dut.regs[0] !== 32'h0) $display("FAIL reset_r0: r0=%h required 00000000", dut.regs[0]);
        else npass++;
        repeat (3) @(negedge clk);
        nchecks++;
        if (writes != w0) $display("FAIL reset_drop: writes=%0d required %0d", writes - w0, 0);
        else npass++;
    endtask

    task automatic test_alu_timing();
        m_in_ready = 1'b1; m_out_ready = 1'b1;
        begin_prog();
        put(32'h01000005); put(32'h01100007); put(32'h02001000); put(32'h1F000000);
        release_reset();
        nchecks++;
        if (m_in_addr !== 32'h0) $display("FAIL first_fetch: m_in_addr=%h required 00000000", m_in_addr);
        else npass++;
        repeat (5) @(posedge clk);
        @(negedge clk);
        nchecks++;
        if (dut.regs[0] !== 32'd5) $display("FAIL alu_t5: r0=%h required 00000005", dut.regs[0]);
        else npass++;
        @(posedge clk);
        @(negedge clk);
        nchecks++;
        if (dut.regs[0] !== 32'd12 || m_in_addr !== 32'd12)
            $display("FAIL alu_t6: r0=%h pc=%h required 0000000c/0000000c", dut.regs[0], m_in_addr);
        else npass++;
    endtask

    task automatic test_alu_ops();
        logic [31:0] v1, v2, r3;
        bit ok;
        v1 = 32'h0000_7FF0; v2 = 32'hFFFF_8005;
        m_in_ready = 1'b1; m_out_ready = 1'b1;
        begin_prog();
        put(enc(8'h01, 4'd1, 4'd0, 16'h7FF0));
        put(enc(8'h01, 4'd2, 4'd0, 16'h8005));
        put(enc(8'h01, 4'd9, 4'd0, 16'h0100));
        put(enc(8'h01, 4'd5, 4'd0, 16'h0004));
        put(enc(8'h03, 4'd3, 4'd1, 16'h2000)); put(enc(8'h0C, 4'd3, 4'd9, 16'h0000)); push(32'h100, v1 - v2, 2'd3);
        put(enc(8'h04, 4'd3, 4'd1, 16'h2000)); put(enc(8'h0C, 4'd3, 4'd9, 16'h0004)); push(32'h104, v1 & v2, 2'd3);
        put(enc(8'h05, 4'd3, 4'd1, 16'h2000)); put(enc(8'h0C, 4'd3, 4'd9, 16'h0008)); push(32'h108, v1 | v2, 2'd3);
        put(enc(8'h06, 4'd3, 4'd1, 16'h2000)); put(enc(8'h0C, 4'd3, 4'd9, 16'h000C)); push(32'h10C, v1 ^ v2, 2'd3);
        put(enc(8'h08, 4'd3, 4'd2, 16'h5000)); put(enc(8'h0C, 4'd3, 4'd9, 16'h0010)); push(32'h110, v2 << 4, 2'd3);
        put(enc(8'h09, 4'd3, 4'd2, 16'h5000)); put(enc(8'h0C, 4'd3, 4'd9, 16'h0014)); push(32'h114, v2 >> 4, 2'd3);
        r3 = v1 + 32'hFFFF_FFF0;
        put(enc(8'h07, 4'd3, 4'd1, 16'hFFF0)); put(enc(8'h0C, 4'd3, 4'd9, 16'h0018)); push(32'h118, r3, 2'd3);
        put(enc(8'h13, 4'd3, 4'd1, 16'h2000)); put(enc(8'h0C, 4'd3, 4'd9, 16'h001C)); push(32'h11C, r3, 2'd3);
`ifdef CPU_MUL_EN
        r3 = v1 * v2;
`endif
        put(enc(8'h12, 4'd3, 4'd1, 16'h2000)); put(enc(8'h0C, 4'd3, 4'd9, 16'h0020)); push(32'h120, r3, 2'd3);
        put(enc(8'h02, 4'd3, 4'd1, 16'h2000)); put(enc(8'h0C, 4'd3, 4'd9, 16'h0024)); push(32'h124, v1 + v2, 2'd3);
        put(enc(8'h1F, 4'd0, 4'd0, 16'h0000));
        release_reset();
        drain(400, ok);
        nchecks++;
        if (!ok) $display("FAIL alu_drain: %0d stores pending, required 0", sb.size());
        else npass++;
    endtask

    task automatic test_stores();
        int          addrs [10];
        logic [7:0]  exp_b [10];
        int          s0;
        bit          ok;
        addrs = '{32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45, 32'h46, 32'h48, 32'h49, 32'h47};
        exp_b = '{8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'hFF, 8'h00, 8'h80, 8'h00, 8'h00};
        m_in_ready = 1'b1; m_out_ready = 1'b1;
        begin_prog();
        put(enc(8'h01, 4'd2, 4'd0, 16'hFF80));
        put(enc(8'h01, 4'd3, 4'd0, 16'h0040));
        put(enc(8'h0C, 4'd2, 4'd3, 16'h0000)); push(32'h40, 32'hFFFF_FF80, 2'd3);
        put(enc(8'h0D, 4'd2, 4'd3, 16'h0004)); push(32'h44, 32'hFFFF_FF80, 2'd2);
        put(enc(8'h0E, 4'd2, 4'd3, 16'h0008)); push(32'h48, 32'hFFFF_FF80, 2'd1);
        put(enc(8'h0A, 4'd4, 4'd3, 16'h0000));
        put(enc(8'h0B, 4'd5, 4'd3, 16'h0000));
        put(enc(8'h0C, 4'd4, 4'd3, 16'h0010)); push(32'h50, 32'hFFFF_FF80, 2'd3);
        put(enc(8'h0C, 4'd5, 4'd3, 16'h0014)); push(32'h54, 32'h0000_0080, 2'd3);
        put(enc(8'h1F, 4'd0, 4'd0, 16'h0000));
        s0 = sig_cycles;
        release_reset();
        drain(300, ok);
        nchecks++;
        if (!ok) $display("FAIL store_drain: %0d stores pending, required 0", sb.size());
        else npass++;
        for (int i = 0; i < 10; i++) begin
            nchecks++;
            if (mem[addrs[i]] !== exp_b[i])
                $display("FAIL store_byte: mem[%h]=%h required %h", addrs[i], mem[addrs[i]], exp_b[i]);
            else npass++;
        end
        nchecks++;
        if (sig_cycles - s0 != 5) $display("FAIL store_sig_len: %0d sig cycles, required 5", sig_cycles - s0);
        else npass++;
    endtask

    task automatic test_load_stall();
        bit found, ok;
        m_in_ready = 1'b0; m_out_ready = 1'b1;
        begin_prog();
        put(enc(8'h01, 4'd6, 4'd0, 16'h0040));
        put(enc(8'h0A, 4'd4, 4'd6, 16'h0000));
        put(enc(8'h0B, 4'd5, 4'd6, 16'h0000));
        put(enc(8'h0A, 4'd6, 4'd6, 16'h0000));
        put(enc(8'h01, 4'd7, 4'd0, 16'h0070));
        put(enc(8'h0C, 4'd4, 4'd7, 16'h0000)); push(32'h70, 32'hFFFF_FF80, 2'd3);
        put(enc(8'h0C, 4'd5, 4'd7, 16'h0004)); push(32'h74, 32'h0000_0080, 2'd3);
        put(enc(8'h0C, 4'd6, 4'd7, 16'h0008)); push(32'h78, 32'hFFFF_FF80, 2'd3);
        put(enc(8'h1F, 4'd0, 4'd0, 16'h0000));
        mem[32'h40] = 8'h80; mem[32'h41] = 8'hFF; mem[32'h42] = 8'hFF; mem[32'h43] = 8'hFF;
        release_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nchecks++;
            if (m_in_addr !== 32'h0 || dut.regs[6] !== 32'h0)
                $display("FAIL fetch_stall: addr=%h r6=%h required 00000000/00000000", m_in_addr, dut.regs[6]);
            else npass++;
        end
        @(posedge clk);
        #1 m_in_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (m_in_addr === 32'h40) begin m_in_ready = 1'b0; found = 1'b1; break; end
        end
        nchecks++;
        if (!found) $display("FAIL load_addr: ea 00000040 not seen, required within 40 cycles");
        else npass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nchecks++;
            if (m_in_addr !== 32'h40 || dut.regs[4] !== 32'h0)
                $display("FAIL load_stall: addr=%h r4=%h required 00000040/00000000", m_in_addr, dut.regs[4]);
            else npass++;
        end
        @(posedge clk);
        #1 m_in_ready = 1'b1;
        drain(300, ok);
        nchecks++;
        if (!ok) $display("FAIL load_drain: %0d stores pending, required 0", sb.size());
        else npass++;
    endtask

    task automatic test_branch_loop();
        int taken;
        logic [31:0] prev;
        m_in_ready = 1'b1; m_out_ready = 1'b1;
        begin_prog();
        put(enc(8'h01, 4'd0, 4'd0, 16'h0003));
        put(enc(8'h07, 4'd0, 4'd0, 16'hFFFF));
        put(enc(8'h10, 4'd0, 4'd4, 16'hFFFC));
        put(enc(8'h01, 4'd9, 4'd0, 16'h0080));
        put(enc(8'h0C, 4'd0, 4'd9, 16'h0000)); push(32'h80, 32'h0, 2'd3);
        put(enc(8'h1F, 4'd0, 4'd0, 16'h0000));
        release_reset();
        taken = 0;
        prev = m_in_addr;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev === 32'd12 && m_in_addr === 32'd4) taken++;
            prev = m_in_addr;
        end
        nchecks++;
        if (taken != 2) $display("FAIL bne_taken: %0d taken, required 2", taken);
        else npass++;
        nchecks++;
        if (sb.size() != 0) $display("FAIL bne_drain: %0d stores pending, required 0", sb.size());
        else npass++;
    endtask

    task automatic test_jmp();
        int n4, bad;
        m_in_ready = 1'b1; m_out_ready = 1'b1;
        begin_prog();
        put(enc(8'h01, 4'd1, 4'd0, 16'h0001));
        put(enc(8'h07, 4'd1, 4'd1, 16'h0001));
        put(enc(8'h11, 4'd0, 4'd0, 16'hFFFC));
        put(enc(8'h1F, 4'd0, 4'd0, 16'h0000));
        release_reset();
        repeat (4) @(negedge clk);
        n4 = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_in_addr === 32'd4) n4++;
            else if (m_in_addr !== 32'd8 && m_in_addr !== 32'd12) bad++;
        end
        nchecks++;
        if (n4 < 8 || bad != 0) $display("FAIL jmp_loop: visits of 4=%0d stray=%0d, required >=8/0", n4, bad);
        else npass++;
    endtask

    task automatic test_backpressure_halt();
        bit found, ok, changed;
        int w0, s0;
        logic [31:0] a;
        m_in_ready = 1'b1; m_out_ready = 1'b0;
        begin_prog();
        put(enc(8'h01, 4'd2, 4'd0, 16'h1234));
        put(enc(8'h01, 4'd3, 4'd0, 16'h0060));
        put(enc(8'h0C, 4'd2, 4'd3, 16'h0000)); push(32'h60, 32'h0000_1234, 2'd3);
        put(enc(8'h1F, 4'd0, 4'd0, 16'h0000));
        w0 = writes; s0 = sig_cycles;
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m_out_sig_write != 2'd0) begin found = 1'b1; break; end
        end
        nchecks++;
        if (!found) $display("FAIL bp_start: sig stayed 0, required nonzero within 30 cycles");
        else npass++;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            nchecks++;
            if (m_out_sig_write !== 2'd3 || m_out_addr !== 32'h60 || m_out_data !== 32'h1234)
                $display("FAIL bp_hold: sig=%0d addr=%h data=%h required 3/00000060/00001234",
                         m_out_sig_write, m_out_addr, m_out_data);
            else npass++;
            @(posedge clk);
        end
        #1 m_out_ready = 1'b1;
        drain(50, ok);
        nchecks++;
        if (!ok || writes - w0 != 1 || sig_cycles - s0 != 5)
            $display("FAIL bp_single: writes=%0d sig cycles=%0d, required 1/5", writes - w0, sig_cycles - s0);
        else npass++;
        repeat (6) @(negedge clk);
        a = m_in_addr;
        changed = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_in_addr !== a || m_out_sig_write !== 2'd0) changed = 1'b1;
        end
        nchecks++;
        if (changed || a !== 32'd16) $display("FAIL halt_idle: addr=%h moved=%0d, required 00000010/0", a, changed);
        else npass++;
    endtask

    initial begin
        test_reset();
        test_alu_timing();
        test_alu_ops();
        test_stores();
        test_load_stall();
        test_branch_loop();
        test_jmp();
        test_backpressure_halt();
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
